// File: rtl/regfile_2r1w.sv
// Two-read/one-write register bank with byte-enable writes, write-first forwarding
// and a sequenced bulk-clear engine reporting busy/done.
module regfile_2r1w #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDR  = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [ADDR-1:0]      i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic [WIDTH/8-1:0]   i_wr_byte_en,
  input  logic                 i_rd_en_a,
  input  logic [ADDR-1:0]      i_rd_addr_a,
  output logic [WIDTH-1:0]     o_rd_data_a,
  output logic                 o_rd_valid_a,
  input  logic                 i_rd_en_b,
  input  logic [ADDR-1:0]      i_rd_addr_b,
  output logic [WIDTH-1:0]     o_rd_data_b,
  output logic                 o_rd_valid_b,
  input  logic                 i_clr_req,
  output logic                 o_busy,
  output logic                 o_clr_done
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam logic [ADDR:0]   DepthL  = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR-1:0] LastIdx = ADDR'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_rd_data_a;
  logic [WIDTH-1:0]   r_rd_data_b;
  logic               r_rd_valid_a;
  logic               r_rd_valid_b;
  logic               r_clr_done;

  logic               w_idle;
  logic               w_clearing;
  logic               w_last;
  logic               w_wr_in_range;
  logic               w_rd_in_range_a;
  logic               w_rd_in_range_b;
  logic               w_wr_accept;
  logic               w_rd_fire_a;
  logic               w_rd_fire_b;
  logic [WIDTH-1:0]   w_wr_old;
  logic [WIDTH-1:0]   w_wr_merged;
  logic [WIDTH-1:0]   w_rd_val_a;
  logic [WIDTH-1:0]   w_rd_val_b;

  assign w_idle     = (r_state == StIdle);
  assign w_clearing = (r_state == StClear);
  assign w_last     = (r_cnt == LastIdx);

  assign w_wr_in_range   = ({1'b0, i_wr_addr}   < DepthL);
  assign w_rd_in_range_a = ({1'b0, i_rd_addr_a} < DepthL);
  assign w_rd_in_range_b = ({1'b0, i_rd_addr_b} < DepthL);

  // A clear request in the same cycle pre-empts the write.
  assign w_wr_accept = w_idle && !i_clr_req && i_wr_en && w_wr_in_range;
  assign w_rd_fire_a = w_idle && i_rd_en_a;
  assign w_rd_fire_b = w_idle && i_rd_en_b;

  always_comb begin
    w_wr_old    = w_wr_in_range ? r_mem[i_wr_addr] : '0;
    w_wr_merged = w_wr_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (i_wr_byte_en[i]) begin
        w_wr_merged[8*i +: 8] = i_wr_data[8*i +: 8];
      end
    end
  end

  // Write-first: a read hitting the address being written sees the merged word.
  always_comb begin
    w_rd_val_a = '0;
    if (w_rd_in_range_a) begin
      if (w_wr_accept && (i_wr_addr == i_rd_addr_a)) begin
        w_rd_val_a = w_wr_merged;
      end else begin
        w_rd_val_a = r_mem[i_rd_addr_a];
      end
    end
  end

  always_comb begin
    w_rd_val_b = '0;
    if (w_rd_in_range_b) begin
      if (w_wr_accept && (i_wr_addr == i_rd_addr_b)) begin
        w_rd_val_b = w_wr_merged;
      end else begin
        w_rd_val_b = r_mem[i_rd_addr_b];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_clr_req) w_state_next = StClear;
      StClear: if (w_last)    w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= w_clearing && w_last;
      if (w_clearing) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clearing) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_accept) begin
      r_mem[i_wr_addr] <= w_wr_merged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data_a  <= '0;
      r_rd_data_b  <= '0;
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
    end else begin
      r_rd_valid_a <= w_rd_fire_a;
      r_rd_valid_b <= w_rd_fire_b;
      if (w_rd_fire_a) r_rd_data_a <= w_rd_val_a;
      if (w_rd_fire_b) r_rd_data_b <= w_rd_val_b;
    end
  end

  assign o_rd_data_a  = r_rd_data_a;
  assign o_rd_data_b  = r_rd_data_b;
  assign o_rd_valid_a = r_rd_valid_a;
  assign o_rd_valid_b = r_rd_valid_b;
  assign o_busy       = w_clearing;
  assign o_clr_done   = r_clr_done;

endmodule
